intan_seq: RTL
==============

Name: intan_seq

Overview:
- Command sequencer for one Intan RHD front end.
- Services the fs_check/fs_conf/fs_read requests from the top-level controller.
- Issues 16-bit Intan command words to the SPI master over a 4-phase handshake, and captures the returned words.
- Check: identifies the chip and sets dev_kind. Read: pushes converted samples into the fifoi 16-bit write port (fifoi_txd/fifoi_txen).

Parameters:
- CONF_NUM, 18, number of register writes in the configuration pass (registers 0..CONF_NUM-1).
- PIPE_LAT, 2, SPI result latency in commands (the result of command k returns during command k+2).
- CAL_DUMMY, 9, dummy commands issued after CALIBRATE.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- err  out  1  sticky error flag; cleared only by reset
- fs_check  in  1  check request (level, 4-phase)
- fs_conf  in  1  configure request
- fs_read  in  1  one-frame read request
- fd_check  out  1  check done
- fd_conf  out  1  configure done
- fd_read  out  1  read done
- dev_kind  out  2  00 none, 01 2116, 10 2132, 11 2164
- spi_fs  out  1  command valid to SPI master
- spi_txd  out  16  command word
- spi_fd  in  1  SPI transfer done; spi_rxd valid while high
- spi_rxd  in  16  returned word
- fifoi_txen  out  1  one-cycle FIFO write strobe
- fifoi_txd  out  16  sample to FIFO
- fifoi_full  in  1  FIFO full

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Request handshake:
  - fd_x rises when operation x completes and stays high while fs_x is high.
  - fd_x drops the cycle after fs_x is seen low. The FSM then returns to IDLE.
  - In IDLE, priority when several requests are high: check > conf > read.
  - Requests are ignored outside IDLE.
- SPI handshake, per command:
  - ISSUE: spi_fs=1 with spi_txd stable until spi_fd=1. spi_rxd is registered in that cycle.
  - RELEASE: spi_fs=0 until spi_fd=0, then advance the index.
- Command encoding:
  - CONVERT(c) = {2'b00, c[5:0], 8'h00}
  - CALIBRATE = 16'h5500
  - WRITE(r,d) = {2'b10, r[5:0], d}
  - READ(r) = {2'b11, r[5:0], 8'h00}
  - Dummy command = READ(63).
- Result capture: the result of command k is captured at completion of command k+PIPE_LAT. Each sequence appends PIPE_LAT dummy commands so that every result is drained.
- CHECK sequence:
  - Commands: READ 40..44, READ 63, then 2 dummies (8 commands).
  - Low bytes of results 0..4 must equal "INTAN" (49 4E 54 41 4E).
  - Result 5 low byte is the chip ID: 1 -> dev_kind 10, 2 -> 01, 4 -> 11.
  - On a string mismatch or an unknown ID: dev_kind=00 and err=1.
  - dev_kind updates on the cycle fd_check rises.
- CONF sequence:
  - Commands: WRITE(r, CONF_ROM[r]) for r=0..CONF_NUM-1, then CALIBRATE, then CAL_DUMMY dummies.
  - Results are ignored. fd_conf is asserted after the last dummy.
  - fs_conf with dev_kind=00: no commands issued, fd_conf asserted at once, err=1.
- READ sequence:
  - N = 16/32/64 per dev_kind.
  - Commands: CONVERT 0..N-1, then PIPE_LAT dummies.
  - On each result capture with index >= PIPE_LAT: fifoi_txd = spi_rxd and fifoi_txen = 1 for exactly one cycle. This gives exactly N pushes, in channel order.
  - Stall: if fifoi_full=1 when the next command would start ISSUE, the FSM holds in a stall state before ISSUE; no command is issued and no data is lost. A push is never attempted while fifoi_full=1.
  - dev_kind=00: fd_read asserted immediately, zero pushes, err=1.
- States: IDLE, ISSUE, RELEASE, EVAL (check compare / push), STALL, DONE.
  - An op register holds CHK/CONF/READ.
  - A 7-bit command index counts up to the sequence length minus 1.
- Reset mid-operation: asynchronous return to IDLE, all outputs 0, and dev_kind reverts to 00. The SPI master must tolerate spi_fs dropping.
- A request that drops before its fd rises is protocol misuse. The sequence still completes, then the FSM waits in DONE.

Decomposition:
- Package intan_pkg:
  - op codes and state encoding
  - dev_kind encodings
  - command opcodes (CONVERT, CALIBRATE, WRITE, READ)
  - register addresses 40..44 and 63
  - the expected "INTAN" bytes and the chip-ID constants
  - CONF_ROM, an array of 18 bytes
- One sub-module, intan_cmd_gen: combinational mapping of (op, index, dev_kind) to {spi_txd, is_last, capture_en}. This keeps the FSM generic.

Test Plan:
- Chip-ID detect:
  - Stimulus: fs_check with the model returning "INTAN" and ID 4.
  - Response: exactly 8 commands, C000 ordered 0xE800..0xEC00 then 0xFF00 x3; dev_kind=11, err=0, fd_check high until fs_check drops.
- Bad check:
  - Stimulus: fs_check with byte 2 returned as 0x00.
  - Response: dev_kind=00, err=1.
- Configure:
  - Stimulus: fs_conf after a check that detected ID 1.
  - Response: 18 WRITE words matching CONF_ROM (first word {2'b10, 6'd0, CONF_ROM[0]}), then 0x5500, then 9x 0xFF00; no fifoi_txen.
- Read:
  - Stimulus: fs_read with dev_kind=10 and the model returning 0x1000+channel.
  - Response: 34 commands; 32 pushes with values 0x1000..0x101F, in order.
- FIFO stall:
  - Stimulus: hold fifoi_full=1 for 20 cycles mid-read.
  - Response: spi_fs stays low throughout; the push count is still 32 with no duplicates.
- Mid-sequence reset and priority:
  - Stimulus: assert rst low during the 10th CONVERT.
  - Response: all outputs 0 asynchronously.
  - Stimulus: raise fs_check and fs_read in the same cycle.
  - Response: the check runs first.

Source files
------------

// File: rtl/intan_pkg.sv
// Shared types and constants for the Intan RHD command sequencer: op codes,
// FSM states, device kinds, command encoders and the configuration ROM.
package intan_pkg;

  localparam int CONF_NUM_DEF  = 18;
  localparam int PIPE_LAT_DEF  = 2;
  localparam int CAL_DUMMY_DEF = 9;
  localparam int ID_LEN        = 5;

  typedef enum logic [1:0] {
    OP_CHK  = 2'd0,
    OP_CONF = 2'd1,
    OP_READ = 2'd2
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_RELEASE = 3'd2,
    ST_EVAL    = 3'd3,
    ST_STALL   = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam logic [1:0] DK_NONE = 2'b00;
  localparam logic [1:0] DK_2116 = 2'b01;
  localparam logic [1:0] DK_2132 = 2'b10;
  localparam logic [1:0] DK_2164 = 2'b11;

  localparam logic [1:0]  OPC_CONVERT   = 2'b00;
  localparam logic [1:0]  OPC_WRITE     = 2'b10;
  localparam logic [1:0]  OPC_READ      = 2'b11;
  localparam logic [15:0] CMD_CALIBRATE = 16'h5500;

  localparam logic [5:0] REG_ID0  = 6'd40;
  localparam logic [5:0] REG_CHIP = 6'd63;

  localparam logic [7:0] ID_2132 = 8'd1;
  localparam logic [7:0] ID_2116 = 8'd2;
  localparam logic [7:0] ID_2164 = 8'd4;

  localparam logic [7:0] CONF_ROM [CONF_NUM_DEF] = '{
    8'hDE, 8'h20, 8'h28, 8'h02, 8'h96, 8'h00, 8'h00, 8'h00, 8'h11,
    8'h80, 8'h10, 8'h80, 8'h2C, 8'h86, 8'hFF, 8'hFF, 8'hFF, 8'hFF
  };

  function automatic logic [15:0] cmd_convert(input logic [5:0] c);
    return {OPC_CONVERT, c, 8'h00};
  endfunction

  function automatic logic [15:0] cmd_write(input logic [5:0] r, input logic [7:0] d);
    return {OPC_WRITE, r, d};
  endfunction

  function automatic logic [15:0] cmd_read(input logic [5:0] r);
    return {OPC_READ, r, 8'h00};
  endfunction

  localparam logic [15:0] CMD_DUMMY = {OPC_READ, REG_CHIP, 8'h00};

  // ASCII "INTAN", returned in the low byte of registers 40..44
  function automatic logic [7:0] intan_char(input logic [2:0] i);
    case (i)
      3'd0:    return 8'h49;
      3'd1:    return 8'h4E;
      3'd2:    return 8'h54;
      3'd3:    return 8'h41;
      3'd4:    return 8'h4E;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [1:0] chip_kind(input logic [7:0] id);
    case (id)
      ID_2132: return DK_2132;
      ID_2116: return DK_2116;
      ID_2164: return DK_2164;
      default: return DK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/intan_cmd_gen.sv
// Maps (op, command index, device kind) to the command word, the end-of-sequence
// flag and whether this command's completion carries a result worth capturing.
module intan_cmd_gen
  import intan_pkg::*;
#(
  parameter int CONF_NUM  = CONF_NUM_DEF,
  parameter int PIPE_LAT  = PIPE_LAT_DEF,
  parameter int CAL_DUMMY = CAL_DUMMY_DEF
) (
  input  op_e         op,
  input  logic [6:0]  idx,
  input  logic [1:0]  dev_kind,
  output logic [15:0] txd,
  output logic        is_last,
  output logic        capture_en
);

  logic [6:0] n_chan;
  logic [6:0] last_idx;

  always_comb begin
    case (dev_kind)
      DK_2116: n_chan = 7'd16;
      DK_2132: n_chan = 7'd32;
      DK_2164: n_chan = 7'd64;
      default: n_chan = 7'd0;
    endcase
  end

  // Every sequence ends with PIPE_LAT (or CAL_DUMMY) dummies; anything past the
  // real commands falls through to the dummy default.
  always_comb begin
    txd        = CMD_DUMMY;
    last_idx   = '0;
    capture_en = 1'b0;
    case (op)
      OP_CHK: begin
        last_idx   = 7'(ID_LEN + PIPE_LAT);
        capture_en = idx >= 7'(PIPE_LAT);
        if (idx < 7'(ID_LEN))
          txd = cmd_read(REG_ID0 + idx[5:0]);
        else if (idx == 7'(ID_LEN))
          txd = cmd_read(REG_CHIP);
      end
      OP_CONF: begin
        last_idx = 7'(CONF_NUM + CAL_DUMMY);
        if (idx < 7'(CONF_NUM))
          txd = cmd_write(idx[5:0], CONF_ROM[idx[4:0]]);
        else if (idx == 7'(CONF_NUM))
          txd = CMD_CALIBRATE;
      end
      OP_READ: begin
        last_idx   = n_chan + 7'(PIPE_LAT - 1);
        capture_en = idx >= 7'(PIPE_LAT);
        if (idx < n_chan)
          txd = cmd_convert(idx[5:0]);
      end
      default: ;
    endcase
  end

  assign is_last = (idx == last_idx);

endmodule

// File: rtl/intan_seq.sv
// Intan RHD command sequencer: runs check/configure/read sequences over a
// 4-phase SPI handshake and pushes converted samples into the input FIFO.
module intan_seq
  import intan_pkg::*;
#(
  parameter int CONF_NUM  = CONF_NUM_DEF,
  parameter int PIPE_LAT  = PIPE_LAT_DEF,
  parameter int CAL_DUMMY = CAL_DUMMY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        err,
  input  logic        fs_check,
  input  logic        fs_conf,
  input  logic        fs_read,
  output logic        fd_check,
  output logic        fd_conf,
  output logic        fd_read,
  output logic [1:0]  dev_kind,
  output logic        spi_fs,
  output logic [15:0] spi_txd,
  input  logic        spi_fd,
  input  logic [15:0] spi_rxd,
  output logic        fifoi_txen,
  output logic [15:0] fifoi_txd,
  input  logic        fifoi_full
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [6:0]  idx_q, idx_d;
  logic [15:0] rx_q, rx_d;
  logic [1:0]  dev_kind_q, dev_kind_d;
  logic        err_q, err_d;
  logic        chk_bad_q, chk_bad_d;

  logic [15:0] cmd_txd;
  logic        is_last;
  logic        cap_en;
  logic        push;
  logic        advance;
  logic        fs_cur;
  logic [6:0]  res_idx;

  intan_cmd_gen #(
    .CONF_NUM  (CONF_NUM),
    .PIPE_LAT  (PIPE_LAT),
    .CAL_DUMMY (CAL_DUMMY)
  ) u_cmd_gen (
    .op         (op_q),
    .idx        (idx_q),
    .dev_kind   (dev_kind_q),
    .txd        (cmd_txd),
    .is_last    (is_last),
    .capture_en (cap_en)
  );

  // rx_q holds the result of command idx_q - PIPE_LAT
  assign res_idx = idx_q - 7'(PIPE_LAT);

  always_comb begin
    case (op_q)
      OP_CHK:  fs_cur = fs_check;
      OP_CONF: fs_cur = fs_conf;
      default: fs_cur = fs_read;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    idx_d      = idx_q;
    rx_d       = rx_q;
    dev_kind_d = dev_kind_q;
    err_d      = err_q;
    chk_bad_d  = chk_bad_q;
    push       = 1'b0;
    advance    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (fs_check) begin
          op_d      = OP_CHK;
          chk_bad_d = 1'b0;
          state_d   = ST_ISSUE;
        end else if (fs_conf) begin
          op_d = OP_CONF;
          if (dev_kind_q == DK_NONE) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
        end else if (fs_read) begin
          op_d = OP_READ;
          if (dev_kind_q == DK_NONE) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = fifoi_full ? ST_STALL : ST_ISSUE;
          end
        end
      end
      ST_STALL: begin
        if (!fifoi_full) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (spi_fd) begin
          rx_d    = spi_rxd;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!spi_fd) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        advance = 1'b1;
        if (cap_en) begin
          if (op_q == OP_CHK && res_idx < 7'(ID_LEN) &&
              rx_q[7:0] != intan_char(res_idx[2:0]))
            chk_bad_d = 1'b1;
          // A sample waits here rather than being dropped while the FIFO is full
          if (op_q == OP_READ) begin
            if (fifoi_full) advance = 1'b0;
            else            push    = 1'b1;
          end
        end
        if (advance) begin
          if (is_last) begin
            state_d = ST_DONE;
            if (op_q == OP_CHK) begin
              if (chk_bad_q || chip_kind(rx_q[7:0]) == DK_NONE) begin
                dev_kind_d = DK_NONE;
                err_d      = 1'b1;
              end else begin
                dev_kind_d = chip_kind(rx_q[7:0]);
              end
            end
          end else begin
            idx_d   = idx_q + 7'd1;
            state_d = (op_q == OP_READ && fifoi_full) ? ST_STALL : ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        if (!fs_cur) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_CHK;
      idx_q      <= '0;
      rx_q       <= '0;
      dev_kind_q <= DK_NONE;
      err_q      <= 1'b0;
      chk_bad_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      rx_q       <= rx_d;
      dev_kind_q <= dev_kind_d;
      err_q      <= err_d;
      chk_bad_q  <= chk_bad_d;
    end
  end

  assign spi_fs     = (state_q == ST_ISSUE);
  assign spi_txd    = spi_fs ? cmd_txd : 16'h0000;
  assign fifoi_txen = push;
  assign fifoi_txd  = rx_q;
  assign fd_check   = (state_q == ST_DONE) && (op_q == OP_CHK);
  assign fd_conf    = (state_q == ST_DONE) && (op_q == OP_CONF);
  assign fd_read    = (state_q == ST_DONE) && (op_q == OP_READ);
  assign dev_kind   = dev_kind_q;
  assign err        = err_q;

endmodule
